// File: rtl/freelist.sv
// Physical-register free list for a two-wide rename stage: a circular array of
// free prds with wrap-bit pointers, commit-driven frees and walk rollback.
module freelist #(
    parameter int PREG_W   = 6,
    parameter int FL_DEPTH = 32,
    parameter int NUM_LREG = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        instr0_alloc_req,
    input  logic                        instr1_alloc_req,
    input  logic                        rename_fire,
    output logic                        freelist_can_alloc,
    output logic [PREG_W-1:0]           freelist2rename_instr0_prd,
    output logic [PREG_W-1:0]           freelist2rename_instr1_prd,
    input  logic                        commits0_free_valid,
    input  logic                        commits1_free_valid,
    input  logic [PREG_W-1:0]           commits0_free_preg,
    input  logic [PREG_W-1:0]           commits1_free_preg,
    input  logic [1:0]                  rob_state,
    input  logic                        rob_walk0_valid,
    input  logic                        rob_walk1_valid,
    output logic [$clog2(FL_DEPTH):0]   freelist_count,
    output logic                        freelist_err
);

    localparam int IDX_W = $clog2(FL_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [1:0] ROB_IDLE          = 2'd0;
    localparam logic [1:0] ROB_OVERWRITE_RAT = 2'd1;
    localparam logic [1:0] ROB_WALKING       = 2'd2;

    localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(FL_DEPTH);

    logic [PREG_W-1:0] entries [FL_DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;
    logic [PTR_W-1:0] head_plus1;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] count_next;
    logic [1:0]       alloc_num;
    logic [1:0]       walk_num;
    logic [1:0]       free_num;
    logic [IDX_W-1:0] free1_idx;
    logic             rob_idle;
    logic             rob_walking;
    logic             alloc_fire;
    logic             err_set;

    assign rob_idle    = (rob_state == ROB_IDLE);
    assign rob_walking = (rob_state == ROB_WALKING);

    assign alloc_num = {1'b0, instr0_alloc_req} + {1'b0, instr1_alloc_req};
    assign walk_num  = {1'b0, rob_walk0_valid}  + {1'b0, rob_walk1_valid};
    assign free_num  = {1'b0, commits0_free_valid} + {1'b0, commits1_free_valid};

    // Pointers carry a wrap bit, so tail - head is the occupancy even when full.
    assign count          = tail - head;
    assign freelist_count = count;

    // Uses the registered count only: a prd freed this cycle is not offered yet.
    assign freelist_can_alloc = (count >= PTR_W'(alloc_num)) && rob_idle;
    assign alloc_fire         = rename_fire && freelist_can_alloc;

    assign head_plus1 = head + PTR_W'(1);
    assign freelist2rename_instr0_prd = entries[head[IDX_W-1:0]];
    assign freelist2rename_instr1_prd = instr0_alloc_req ? entries[head_plus1[IDX_W-1:0]]
                                                         : entries[head[IDX_W-1:0]];

    assign free1_idx = tail[IDX_W-1:0] + IDX_W'(commits0_free_valid);

    always_comb begin
        head_next = head;
        // Walk rollback reclaims prds by moving head back; the slots still hold them.
        if (rob_walking) begin
            head_next = head - PTR_W'(walk_num);
        end else if (alloc_fire) begin
            head_next = head + PTR_W'(alloc_num);
        end
        tail_next  = tail + PTR_W'(free_num);
        count_next = tail_next - head_next;
        err_set    = (count_next > FULL_COUNT);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head         <= '0;
            tail         <= FULL_COUNT;
            freelist_err <= 1'b0;
        end else begin
            head <= head_next;
            tail <= tail_next;
            if (err_set) begin
                freelist_err <= 1'b1;
            end
        end
    end

    // NOTE: the array is reset because its initial contents (the non-arch prds)
    // are visible to rename right after reset; this keeps it in flops, not RAM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entries[i] <= PREG_W'(NUM_LREG + i);
            end
        end else begin
            if (commits0_free_valid) begin
                entries[tail[IDX_W-1:0]] <= commits0_free_preg;
            end
            if (commits1_free_valid) begin
                entries[free1_idx] <= commits1_free_preg;
            end
        end
    end

endmodule

// File: tb/tb_freelist.sv
// Self-checking bench for freelist: directed scenarios plus constrained-random
// traffic against a queue-based model of the free list.
module tb_freelist;

    localparam int PREG_W   = 6;
    localparam int FL_DEPTH = 32;
    localparam int NUM_LREG = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OVR  = 2'd1;
    localparam logic [1:0] ST_WALK = 2'd2;

    logic              clk = 1'b0;
    logic              reset;
    logic              instr0_alloc_req;
    logic              instr1_alloc_req;
    logic              rename_fire;
    logic              freelist_can_alloc;
    logic [PREG_W-1:0] prd0;
    logic [PREG_W-1:0] prd1;
    logic              commits0_free_valid;
    logic              commits1_free_valid;
    logic [PREG_W-1:0] commits0_free_preg;
    logic [PREG_W-1:0] commits1_free_preg;
    logic [1:0]        rob_state;
    logic              rob_walk0_valid;
    logic              rob_walk1_valid;
    logic [5:0]        freelist_count;
    logic              freelist_err;

    int checks   = 0;
    int failures = 0;

    // Model: fl holds free prds in issue order; hist holds issued prds, newest last.
    logic [PREG_W-1:0] fl[$];
    logic [PREG_W-1:0] hist[$];
    bit                m_err;

    freelist #(.PREG_W(PREG_W), .FL_DEPTH(FL_DEPTH), .NUM_LREG(NUM_LREG)) dut (
        .clock                      (clk),
        .reset                      (reset),
        .instr0_alloc_req           (instr0_alloc_req),
        .instr1_alloc_req           (instr1_alloc_req),
        .rename_fire                (rename_fire),
        .freelist_can_alloc         (freelist_can_alloc),
        .freelist2rename_instr0_prd (prd0),
        .freelist2rename_instr1_prd (prd1),
        .commits0_free_valid        (commits0_free_valid),
        .commits1_free_valid        (commits1_free_valid),
        .commits0_free_preg         (commits0_free_preg),
        .commits1_free_preg         (commits1_free_preg),
        .rob_state                  (rob_state),
        .rob_walk0_valid            (rob_walk0_valid),
        .rob_walk1_valid            (rob_walk1_valid),
        .freelist_count             (freelist_count),
        .freelist_err               (freelist_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        fl.delete();
        hist.delete();
        for (int i = 0; i < FL_DEPTH; i++) fl.push_back(PREG_W'(NUM_LREG + i));
        m_err = 1'b0;
    endfunction

    task automatic check_outputs(input string tag);
        int cnt  = fl.size();
        int need = int'(instr0_alloc_req) + int'(instr1_alloc_req);
        check({tag, ".can_alloc"}, 32'(freelist_can_alloc),
              32'((cnt >= need) && (rob_state == ST_IDLE)));
        check({tag, ".count"}, 32'(freelist_count), 32'(cnt % 64));
        check({tag, ".err"}, 32'(freelist_err), 32'(m_err));
        // After an overflow the slot contents are no longer defined by the model.
        if (!m_err) begin
            if (cnt >= 1) check({tag, ".prd0"}, 32'(prd0), 32'(fl[0]));
            if (instr0_alloc_req && cnt >= 2) check({tag, ".prd1"}, 32'(prd1), 32'(fl[1]));
            if (!instr0_alloc_req && cnt >= 1) check({tag, ".prd1"}, 32'(prd1), 32'(fl[0]));
        end
    endtask

    task automatic drive(input string tag, input logic r0, input logic r1, input logic fire,
                         input logic [1:0] st, input logic f0, input logic f1,
                         input logic [5:0] p0, input logic [5:0] p1,
                         input logic w0, input logic w1);
        @(negedge clk);
        instr0_alloc_req    = r0;
        instr1_alloc_req    = r1;
        rename_fire         = fire;
        rob_state           = st;
        commits0_free_valid = f0;
        commits1_free_valid = f1;
        commits0_free_preg  = p0;
        commits1_free_preg  = p1;
        rob_walk0_valid     = w0;
        rob_walk1_valid     = w1;
        #1;
        check_outputs(tag);
    endtask

    task automatic tick();
        int cnt  = fl.size();
        int need = int'(instr0_alloc_req) + int'(instr1_alloc_req);
        int an   = (rob_state == ST_IDLE && rename_fire && cnt >= need) ? need : 0;
        int wn   = (rob_state == ST_WALK) ? int'(rob_walk0_valid) + int'(rob_walk1_valid) : 0;
        @(posedge clk);
        for (int k = 0; k < an; k++) hist.push_back(fl.pop_front());
        for (int k = 0; k < wn; k++) if (hist.size() > 0) fl.push_front(hist.pop_back());
        if (commits0_free_valid) fl.push_back(commits0_free_preg);
        if (commits1_free_valid) fl.push_back(commits1_free_preg);
        if (fl.size() > FL_DEPTH) m_err = 1'b1;
    endtask

    task automatic set_idle_inputs();
        instr0_alloc_req    = 1'b0;
        instr1_alloc_req    = 1'b0;
        rename_fire         = 1'b0;
        rob_state           = ST_IDLE;
        commits0_free_valid = 1'b0;
        commits1_free_valid = 1'b0;
        commits0_free_preg  = '0;
        commits1_free_preg  = '0;
        rob_walk0_valid     = 1'b0;
        rob_walk1_valid     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_idle_inputs();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        set_idle_inputs();
        model_reset();
        do_reset();

        // Reset values with both slots requesting.
        drive("rst", 1, 1, 0, ST_IDLE, 0, 0, 0, 0, 0, 0);
        check("rst.count_abs", 32'(freelist_count), 32'd32);
        check("rst.can_abs", 32'(freelist_can_alloc), 32'd1);
        check("rst.prd0_abs", 32'(prd0), 32'd32);
        check("rst.prd1_abs", 32'(prd1), 32'd33);
        check("rst.err_abs", 32'(freelist_err), 32'd0);

        // Drain the list two at a time: 32..63 in order.
        for (int k = 0; k < 16; k++) begin
            drive("drain", 1, 1, 1, ST_IDLE, 0, 0, 0, 0, 0, 0);
            check("drain.prd0_abs", 32'(prd0), 32'(32 + 2 * k));
            check("drain.prd1_abs", 32'(prd1), 32'(33 + 2 * k));
            tick();
        end
        drive("empty", 1, 1, 1, ST_IDLE, 0, 0, 0, 0, 0, 0);
        check("empty.count_abs", 32'(freelist_count), 32'd0);
        check("empty.can_abs", 32'(freelist_can_alloc), 32'd0);
        tick();

        // Dual free into an empty list; frees are not visible the same cycle.
        drive("dfree", 1, 1, 1, ST_IDLE, 1, 1, 6'd40, 6'd41, 0, 0);
        check("dfree.can_same_cycle", 32'(freelist_can_alloc), 32'd0);
        tick();
        drive("dfree_after", 1, 1, 0, ST_IDLE, 0, 0, 0, 0, 0, 0);
        check("dfree.count_abs", 32'(freelist_count), 32'd2);
        check("dfree.prd0_abs", 32'(prd0), 32'd40);
        check("dfree.prd1_abs", 32'(prd1), 32'd41);

        // Count of one: a pair cannot go, a single can.
        drive("one_a", 1, 0, 1, ST_IDLE, 0, 0, 0, 0, 0, 0);
        tick();
        drive("one_pair", 1, 1, 1, ST_IDLE, 0, 0, 0, 0, 0, 0);
        check("one.pair_can_abs", 32'(freelist_can_alloc), 32'd0);
        tick();
        drive("one_single", 1, 0, 1, ST_IDLE, 0, 0, 0, 0, 0, 0);
        check("one.single_can_abs", 32'(freelist_can_alloc), 32'd1);
        check("one.single_prd_abs", 32'(prd0), 32'd41);
        tick();
        drive("one_done", 0, 0, 0, ST_IDLE, 0, 0, 0, 0, 0, 0);
        check("one.count_abs", 32'(freelist_count), 32'd0);

        // Allocate four, then walk them back while fire is held.
        do_reset();
        repeat (2) begin
            drive("walk_alloc", 1, 1, 1, ST_IDLE, 0, 0, 0, 0, 0, 0);
            tick();
        end
        repeat (2) begin
            drive("walk", 1, 1, 1, ST_WALK, 0, 0, 0, 0, 1, 1);
            tick();
        end
        drive("walk_done", 1, 1, 0, ST_IDLE, 0, 0, 0, 0, 0, 0);
        check("walk.count_abs", 32'(freelist_count), 32'd32);
        check("walk.prd0_abs", 32'(prd0), 32'd32);

        // OVERWRITE_RAT holds head but still takes frees.
        drive("ovr_alloc", 1, 1, 1, ST_IDLE, 0, 0, 0, 0, 0, 0);
        tick();
        drive("ovr", 1, 1, 1, ST_OVR, 1, 0, 6'd7, 0, 1, 1);
        tick();
        drive("ovr_done", 0, 0, 0, ST_IDLE, 0, 0, 0, 0, 0, 0);
        check("ovr.count_abs", 32'(freelist_count), 32'd31);
        check("ovr.prd0_abs", 32'(prd0), 32'd34);

        // Overflow from a full list sets a sticky error.
        do_reset();
        drive("ovf", 0, 0, 0, ST_IDLE, 1, 0, 6'd5, 0, 0, 0);
        tick();
        drive("ovf_after", 0, 0, 0, ST_IDLE, 0, 0, 0, 0, 0, 0);
        check("ovf.err_abs", 32'(freelist_err), 32'd1);
        repeat (3) begin
            drive("ovf_hold", 1, 1, 1, ST_IDLE, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drive("ovf_sticky", 0, 0, 0, ST_IDLE, 0, 0, 0, 0, 0, 0);
        check("ovf.err_sticky_abs", 32'(freelist_err), 32'd1);
        do_reset();
        drive("ovf_clear", 0, 0, 0, ST_IDLE, 0, 0, 0, 0, 0, 0);
        check("ovf.err_cleared_abs", 32'(freelist_err), 32'd0);

        // Asynchronous reset in the middle of a walk.
        repeat (2) begin
            drive("arst_alloc", 1, 1, 1, ST_IDLE, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drive("arst_walk", 1, 1, 1, ST_WALK, 0, 0, 0, 0, 1, 0);
        tick();
        drive("arst_walk2", 1, 1, 1, ST_WALK, 1, 0, 6'd9, 0, 1, 1);
        #1 reset = 1'b1;
        #1;
        check("arst.count_abs", 32'(freelist_count), 32'd32);
        check("arst.prd0_abs", 32'(prd0), 32'd32);
        check("arst.prd1_abs", 32'(prd1), 32'd33);
        check("arst.err_abs", 32'(freelist_err), 32'd0);
        rob_state = ST_IDLE;
        #1;
        check("arst.can_abs", 32'(freelist_can_alloc), 32'd1);
        set_idle_inputs();
        @(posedge clk);
        #2 reset = 1'b0;
        model_reset();

        // Constrained-random traffic: overflow is avoided so the model stays exact.
        for (int n = 0; n < 600; n++) begin
            logic [1:0] st;
            logic       r0, r1, fire, f0, f1, w0, w1;
            logic [5:0] p0, p1;
            int         r, cnt, need, an, wn, room;
            r    = int'($urandom_range(0, 9));
            st   = (r < 7) ? ST_IDLE : (r == 7) ? ST_OVR : ST_WALK;
            r0   = 1'($urandom);
            r1   = 1'($urandom);
            fire = 1'($urandom);
            w0   = 1'($urandom);
            w1   = 1'($urandom);
            f0   = 1'($urandom);
            f1   = 1'($urandom);
            p0   = 6'($urandom);
            p1   = 6'($urandom);
            cnt  = fl.size();
            need = int'(r0) + int'(r1);
            an   = (st == ST_IDLE && fire && cnt >= need) ? need : 0;
            wn   = 0;
            if (st == ST_WALK) begin
                wn = int'(w0) + int'(w1);
                if (wn > hist.size() || cnt + wn > FL_DEPTH) begin
                    w1 = 1'b0;
                    wn = int'(w0);
                    if (wn > hist.size() || cnt + wn > FL_DEPTH) begin
                        w0 = 1'b0;
                        wn = 0;
                    end
                end
            end
            room = FL_DEPTH - (cnt - an + wn);
            if (room < 2) f1 = 1'b0;
            if (room < 1) f0 = 1'b0;
            drive("rand", r0, r1, fire, st, f0, f1, p0, p1, w0, w1);
            tick();
        end
        drive("rand_end", 1, 1, 0, ST_IDLE, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule
